// File: rtl/rf_wb_arbiter.sv
// Three-way register-file writeback arbiter (ALU, load, mul/div) with a pending-write scoreboard.
// Define RF_WB_FIXED_PRI_EN for fixed priority m > b > a; the default build is round-robin.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [4:0]  a_rdc,
  input  logic [31:0] a_data,
  output logic        a_gnt,
  input  logic        b_req,
  input  logic [4:0]  b_rdc,
  input  logic [31:0] b_data,
  output logic        b_gnt,
  input  logic        m_req,
  input  logic [4:0]  m_rdc,
  input  logic [31:0] m_data,
  output logic        m_gnt,
  output logic        rf_w,
  output logic [4:0]  rdc,
  output logic [31:0] rd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rdc,
  input  logic [4:0]  rsc,
  input  logic [4:0]  rtc,
  output logic        rs_busy,
  output logic        rt_busy
);

  logic [2:0]  w_req;
  logic [2:0]  w_gnt;
  logic        w_any;
  logic [4:0]  w_sel_rdc;
  logic [31:0] w_sel_data;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_busy_nxt;
  logic        r_rf_w;
  logic [4:0]  r_rdc;
  logic [31:0] r_rd;
  logic [31:0] r_busy;

  // Grants are suppressed while reset is sampled, so pending requests are dropped.
  assign w_req = rst ? 3'b000 : {m_req, b_req, a_req};

`ifdef RF_WB_FIXED_PRI_EN
  // Fixed priority pick: m > b > a.
  always_comb begin
    w_gnt = 3'b000;
    if (w_req[2]) begin
      w_gnt = 3'b100;
    end else if (w_req[1]) begin
      w_gnt = 3'b010;
    end else if (w_req[0]) begin
      w_gnt = 3'b001;
    end else begin
      w_gnt = 3'b000;
    end
  end
`else
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  // Round-robin search starting at the requester after ptr.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      2'd0: begin
        if (req[1])      g = 3'b010;
        else if (req[2]) g = 3'b100;
        else if (req[0]) g = 3'b001;
        else             g = 3'b000;
      end
      2'd1: begin
        if (req[2])      g = 3'b100;
        else if (req[0]) g = 3'b001;
        else if (req[1]) g = 3'b010;
        else             g = 3'b000;
      end
      default: begin
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
        else             g = 3'b000;
      end
    endcase
    return g;
  endfunction

  // Round-robin grant from the last-granted pointer.
  always_comb begin
    w_gnt = rr_pick(w_req, r_ptr);
  end

  // Encode the granted requester index for the pointer update.
  always_comb begin
    case (w_gnt)
      3'b010:  w_idx = 2'd1;
      3'b100:  w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
  end

  // Last-granted pointer; reset value 2 gives requester a first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd2;
    end else if (w_any) begin
      r_ptr <= w_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`endif

  assign w_any = |w_gnt;
  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];
  assign m_gnt = w_gnt[2];

  // Mux the granted requester's index and data.
  always_comb begin
    case (w_gnt)
      3'b010: begin
        w_sel_rdc  = b_rdc;
        w_sel_data = b_data;
      end
      3'b100: begin
        w_sel_rdc  = m_rdc;
        w_sel_data = m_data;
      end
      default: begin
        w_sel_rdc  = a_rdc;
        w_sel_data = a_data;
      end
    endcase
  end

  // Scoreboard next state: clear on writeback grant, set on issue; set wins, bit 0 never busy.
  always_comb begin
    w_set = 32'd0;
    w_clr = 32'd0;
    if (iss_valid && (iss_rdc != 5'd0)) begin
      w_set = 32'd1 << iss_rdc;
    end else begin
      w_set = 32'd0;
    end
    if (w_any && (w_sel_rdc != 5'd0)) begin
      w_clr = 32'd1 << w_sel_rdc;
    end else begin
      w_clr = 32'd0;
    end
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Writeback port: one cycle after the grant; a write to r0 is consumed but not performed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_w <= 1'b0;
      r_rdc  <= 5'd0;
      r_rd   <= 32'd0;
    end else if (w_any) begin
      r_rf_w <= (w_sel_rdc != 5'd0);
      r_rdc  <= w_sel_rdc;
      r_rd   <= w_sel_data;
    end else begin
      r_rf_w <= 1'b0;
      r_rdc  <= r_rdc;
      r_rd   <= r_rd;
    end
  end

  assign rf_w    = r_rf_w;
  assign rdc     = r_rdc;
  assign rd      = r_rd;
  assign rs_busy = r_busy[rsc];
  assign rt_busy = r_busy[rtc];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based requester/scoreboard model predicts grants,
// busy reads and the registered writeback; a monitor pops and compares the writeback each cycle.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req, m_req;
  logic [4:0]  a_rdc, b_rdc, m_rdc;
  logic [31:0] a_data, b_data, m_data;
  logic        a_gnt, b_gnt, m_gnt;
  logic        rf_w;
  logic [4:0]  rdc;
  logic [31:0] rd;
  logic        iss_valid;
  logic [4:0]  iss_rdc, rsc, rtc;
  logic        rs_busy, rt_busy;

  typedef struct packed {
    logic        w;
    logic [4:0]  rdc;
    logic [31:0] rd;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic        pend_v[3];
  logic [4:0]  pend_rdc[3];
  logic [31:0] pend_data[3];
  logic [31:0] busy_m;
  int          ptr;

  // Per-cycle stimulus controls
  logic        t_rst;
  logic        t_iss_v;
  logic [4:0]  t_iss_rdc, t_rsc, t_rtc;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rdc(a_rdc), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_rdc(b_rdc), .b_data(b_data), .b_gnt(b_gnt),
    .m_req(m_req), .m_rdc(m_rdc), .m_data(m_data), .m_gnt(m_gnt),
    .rf_w(rf_w), .rdc(rdc), .rd(rd),
    .iss_valid(iss_valid), .iss_rdc(iss_rdc), .rsc(rsc), .rtc(rtc),
    .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic post(input int i, input logic [4:0] r, input logic [31:0] d);
    if (!pend_v[i]) begin
      pend_v[i]    = 1'b1;
      pend_rdc[i]  = r;
      pend_data[i] = d;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    int         g;
    logic [2:0] exp_g;
    exp_t       e;
    rst = t_rst;
    a_req = pend_v[0]; a_rdc = pend_rdc[0]; a_data = pend_data[0];
    b_req = pend_v[1]; b_rdc = pend_rdc[1]; b_data = pend_data[1];
    m_req = pend_v[2]; m_rdc = pend_rdc[2]; m_data = pend_data[2];
    iss_valid = t_iss_v; iss_rdc = t_iss_rdc; rsc = t_rsc; rtc = t_rtc;
    #1;
    g = -1;
    if (!t_rst) begin
`ifdef RF_WB_FIXED_PRI_EN
      for (int k = 2; k >= 0; k--) if (g < 0 && pend_v[k]) g = k;
`else
      for (int k = 1; k <= 3; k++) if (g < 0 && pend_v[(ptr + k) % 3]) g = (ptr + k) % 3;
`endif
    end
    exp_g = 3'b000;
    if (g >= 0) exp_g[g] = 1'b1;
    check("gnt_mba", 64'({m_gnt, b_gnt, a_gnt}), 64'(exp_g));
    check("rs_busy", 64'(rs_busy), 64'(busy_m[t_rsc]));
    check("rt_busy", 64'(rt_busy), 64'(busy_m[t_rtc]));
    if (t_rst) begin
      busy_m = 32'd0;
      ptr = 2;
      e.w = 1'b0; e.rdc = 5'd0; e.rd = 32'd0; e.full = 1'b1;
    end else begin
      if (g >= 0) begin
        busy_m[pend_rdc[g]] = 1'b0;
        e.w = (pend_rdc[g] != 5'd0);
        e.rdc = pend_rdc[g];
        e.rd = pend_data[g];
        e.full = e.w;
        ptr = g;
        pend_v[g] = 1'b0;
      end else begin
        e.w = 1'b0; e.rdc = 5'd0; e.rd = 32'd0; e.full = 1'b0;
      end
      if (t_iss_v && t_iss_rdc != 5'd0) busy_m[t_iss_rdc] = 1'b1;
      busy_m[0] = 1'b0;
    end
    sb.push_back(e);
    t_iss_v = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compare the registered writeback against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rf_w", 64'(rf_w), 64'(e.w));
        if (e.full) begin
          check("rdc", 64'(rdc), 64'(e.rdc));
          check("rd", 64'(rd), 64'(e.rd));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend_v[i] = 1'b0; pend_rdc[i] = 5'd0; pend_data[i] = 32'd0;
    end
    busy_m = 32'd0; ptr = 2;
    t_rst = 1'b1; t_iss_v = 1'b0; t_iss_rdc = 5'd0; t_rsc = 5'd0; t_rtc = 5'd0;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; m_req = 1'b0;
    a_rdc = 5'd0; b_rdc = 5'd0; m_rdc = 5'd0; a_data = 32'd0; b_data = 32'd0; m_data = 32'd0;
    iss_valid = 1'b0; iss_rdc = 5'd0; rsc = 5'd0; rtc = 5'd0;
    @(negedge clk);
    step(); step();
    t_rst = 1'b0;

    // All three requesting: a, b, m in turn, back-to-back writebacks
    post(0, 5'd1, 32'h1111_0001); post(1, 5'd2, 32'h2222_0002); post(2, 5'd3, 32'h3333_0003);
    step(); step(); step(); step();

    // Issue to r5, observe busy, load writeback clears it
    t_iss_v = 1'b1; t_iss_rdc = 5'd5; step();
    t_rsc = 5'd5; step();
    post(1, 5'd5, 32'hDEAD_BEEF); step();
    step();

    // Writeback to r0 is consumed without a write
    post(0, 5'd0, 32'h0BAD_0000); step(); step();

    // Same-cycle set and clear of r7: set wins
    post(2, 5'd7, 32'h7777_7777); t_iss_v = 1'b1; t_iss_rdc = 5'd7; step();
    t_rtc = 5'd7; step();

    // Reset right after a grant, then all request again
    t_iss_v = 1'b1; t_iss_rdc = 5'd9;
    post(0, 5'd10, 32'hA0A0_A0A0); post(1, 5'd11, 32'hB0B0_B0B0); post(2, 5'd12, 32'hC0C0_C0C0);
    step();
    t_rst = 1'b1; t_rsc = 5'd9; step();
    t_rst = 1'b0;
    post(0, 5'd10, 32'hA0A0_A0A0); post(1, 5'd11, 32'hB0B0_B0B0); post(2, 5'd12, 32'hC0C0_C0C0);
    step(); step(); step(); step();

    // Only m requesting, every cycle
    for (int i = 0; i < 4; i++) begin
      post(2, 5'(i + 20), 32'h5000_0000 + 32'(i));
      step();
    end
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 1) post(i, 5'($urandom_range(0, 31)), $urandom);
      end
      t_iss_v = ($urandom_range(0, 2) != 0);
      t_iss_rdc = 5'($urandom_range(0, 31));
      t_rsc = 5'($urandom_range(0, 31));
      t_rtc = 5'($urandom_range(0, 31));
      t_rst = ($urandom_range(0, 63) == 0);
      step();
    end
    t_rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    @(posedge clk);
    #2;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, synchronous active-high reset).
REQ-002 a_req, input, 1: ALU writeback request.
REQ-003 a_rdc / a_data, input, 5 / 32: ALU destination register index / ALU write data.
REQ-004 a_gnt, output, 1: ALU grant, combinational.
REQ-005 b_req, b_rdc, b_data, b_gnt: load-unit requester; same widths and meanings as REQ-002..004.
REQ-006 m_req, m_rdc, m_data, m_gnt: mul/div requester; same widths and meanings as REQ-002..004.
REQ-007 rf_w, output, 1: registered register-file write enable.
REQ-008 rdc / rd, output, 5 / 32: registered write index / registered write data.
REQ-009 iss_valid, input, 1: an instruction with a destination is issuing.
REQ-010 iss_rdc, input, 5: destination index of the issuing instruction.
REQ-011 rsc / rtc, input, 5: source indices to query.
REQ-012 rs_busy / rt_busy, output, 1: queried register has a pending write (combinational).

Function
REQ-013 At most one of a_gnt, b_gnt, m_gnt SHALL be high in any cycle, and a grant SHALL only be asserted for a requester whose req is high.
REQ-014 Arbitration SHALL be round-robin over the order a(0), b(1), m(2), searching from ptr+1 mod 3, where ptr is the index of the last granted requester.
REQ-015 ptr SHALL update to the granted index on the clock edge of a grant and SHALL hold when no grant is made.
REQ-016 Requesters SHALL hold req, rdc and data stable until they see gnt; the block SHALL sample the granted rdc and data in the grant cycle.
REQ-017 Latency: rf_w/rdc/rd SHALL reflect the granted request exactly one cycle after the grant cycle; rf_w SHALL be low in every cycle that follows a cycle with no grant.
REQ-018 A granted request with rdc==0 SHALL be consumed (gnt high), but the following cycle SHALL have rf_w=0; rdc and rd then hold don't-care values.
REQ-019 The scoreboard SHALL keep a 32-bit busy vector: iss_valid with iss_rdc!=0 sets busy[iss_rdc] at the clock edge.
REQ-020 A grant with rdc!=0 SHALL clear busy[rdc] at the grant-cycle edge, the same edge at which rf_w rises.
REQ-021 When a set and a clear target the same index in the same cycle, the set SHALL win.
REQ-022 busy[0] SHALL always read 0.
REQ-023 rs_busy = busy[rsc] and rt_busy = busy[rtc], both combinational from current state; no bypass of same-cycle sets or clears.
REQ-024 Back-to-back grants SHALL be sustainable at one per cycle with no bubble.

Reset
REQ-025 While rst is sampled high: ptr=2 (so a has first priority), rf_w=0, rdc=0, rd=0, busy vector all 0.
REQ-026 Grant outputs SHALL be forced low during rst, and no grant SHALL be counted during rst.
REQ-027 A request pending when reset asserts SHALL be dropped; the requester re-presents it after reset.

Configuration
REQ-028 With macro RF_WB_FIXED_PRI_EN defined, arbitration SHALL be fixed priority m > b > a, and ptr SHALL not exist or SHALL be ignored.
REQ-029 With RF_WB_FIXED_PRI_EN undefined, round-robin per REQ-014/015 SHALL apply; all other requirements are identical in both builds.

Verification
REQ-030 After reset, a_req=b_req=m_req=1 held for 3 cycles -> grants a, b, m in successive cycles; rf_w=1 for 3 cycles starting one cycle after the first grant (fixed-priority build: m for all 3 cycles).
REQ-031 iss_valid=1, iss_rdc=5; next cycle rsc=5 -> rs_busy=1; then b_req=1, b_rdc=5, b_data=32'hDEADBEEF -> b_gnt the same cycle; next cycle rf_w=1, rdc=5, rd=DEADBEEF, rs_busy=0.
REQ-032 a_req=1 with a_rdc=0 -> a_gnt=1; next cycle rf_w=0; busy vector unchanged.
REQ-033 Same cycle: iss_valid with iss_rdc=7 and grant of m with m_rdc=7 -> busy[7]=1 afterwards; rtc=7 gives rt_busy=1.
REQ-034 rst asserted in the cycle after a grant -> rf_w=0, rdc=0, rd=0, busy all 0 on the next edge; first post-reset grant with all requesting goes to a.
REQ-035 Only m_req held for 4 cycles -> m_gnt high in all 4 cycles and rf_w high for 4 consecutive cycles starting one cycle later.
